mem_stage: RTL and testbench

//  MEM pipeline stage of the 5-stage MIPS core, directly upstream of WB. Registers the EX->MEM bus and

---
 rtl/mem_stage_pkg.sv | 58 +++++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_load_align.sv | 38 +++
 rtl/mem_stage.sv | 86 ++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall-bus indices, load opcodes and bus layouts for the MEM stage.
package mem_stage_pkg;

  localparam int EX2MEM_W  = 146;
  localparam int MEM2WB_W  = 137;
  localparam int MEM2ID_W  = 104;
  localparam int STALL_W   = 6;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    MEM_OP_NONE = 3'b000,
    MEM_OP_LB   = 3'b001,
    MEM_OP_LBU  = 3'b010,
    MEM_OP_LH   = 3'b011,
    MEM_OP_LHU  = 3'b100,
    MEM_OP_LW   = 3'b101
  } mem_op_e;

  typedef struct packed {
    logic [2:0]  mem_op;
    logic        lo_wen;
    logic        hi_wen;
    logic        div_mul_flag;
    logic [63:0] div_mul_result;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic        lo_wen;
    logic        hi_wen;
    logic        div_mul_flag;
    logic [63:0] div_mul_result;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic        lo_wen;
    logic        hi_wen;
    logic [63:0] div_mul_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle between the pipeline and the MEM stage: stall vector, EX input, SRAM data, WB/ID outputs.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [STALL_W-1:0]  stall;
  logic [EX2MEM_W-1:0] ex_to_mem_bus;
  logic [31:0]         data_sram_rdata;
  logic [MEM2WB_W-1:0] mem_to_wb_bus;
  logic [MEM2ID_W-1:0] mem_to_id_bus;

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: selects byte/half/word by address offset and sign/zero-extends.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Misaligned halfword offsets are tolerated: only off[1] picks the half.
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    case (mem_op)
      MEM_OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: load_data = {24'd0, byte_sel};
      MEM_OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: load_data = {16'd0, half_sel};
      MEM_OP_LW:  load_data = rdata;
      default:    load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, holds SRAM read data across stalls,
// aligns loads and drives the WB bus and the ID bypass bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  ex_to_mem_t  ex_in;
  ex_to_mem_t  r;
  logic        hold_valid;
  logic [31:0] rdata_hold;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        mem_stop;
  logic        wb_stop;
  mem_to_wb_t  wb;
  mem_to_id_t  id;
  logic        unused_bits;

  assign ex_in    = ex_to_mem_t'(bus.ex_to_mem_bus);
  assign mem_stop = (bus.stall[STALL_MEM] == STOP);
  assign wb_stop  = (bus.stall[STALL_WB] == STOP);

  // The SRAM word is only valid in the first cycle after the request, so the first
  // held cycle latches it and later held cycles keep that copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r          <= '0;
      hold_valid <= 1'b0;
      rdata_hold <= '0;
    end else if (mem_stop && !wb_stop) begin
      r          <= '0;
      hold_valid <= 1'b0;
    end else if (!mem_stop) begin
      r          <= ex_in;
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      rdata_hold <= bus.data_sram_rdata;
      hold_valid <= 1'b1;
    end
  end

  assign rdata_eff = hold_valid ? rdata_hold : bus.data_sram_rdata;

  load_align u_load_align (
    .mem_op    (r.mem_op),
    .off       (r.ex_result[1:0]),
    .rdata     (rdata_eff),
    .load_data (load_data)
  );

  assign rf_wdata = r.sel_rf_res ? load_data : r.ex_result;

  always_comb begin
    wb                = '0;
    wb.lo_wen         = r.lo_wen;
    wb.hi_wen         = r.hi_wen;
    wb.div_mul_flag   = r.div_mul_flag;
    wb.div_mul_result = r.div_mul_result;
    wb.pc             = r.pc;
    wb.rf_we          = r.rf_we;
    wb.rf_waddr       = r.rf_waddr;
    wb.rf_wdata       = rf_wdata;
  end

  always_comb begin
    id                = '0;
    id.lo_wen         = r.lo_wen;
    id.hi_wen         = r.hi_wen;
    id.div_mul_result = r.div_mul_result;
    id.rf_we          = r.rf_we;
    id.rf_waddr       = r.rf_waddr;
    id.rf_wdata       = rf_wdata;
  end

  assign bus.mem_to_wb_bus = wb;
  assign bus.mem_to_id_bus = id;

  // Store controls and foreign stall bits are carried but not acted on here.
  assign unused_bits = ^{bus.stall[STALL_W-1], bus.stall[2:0], r.data_ram_en, r.data_ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Randomised and directed self-checking bench for mem_stage against a behavioural model.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic running;

  mem_stage_if bus ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The instruction currently in MEM, how many cycles it has sat there, and the
  // SRAM word observed during its first cycle.
  logic [145:0] m_cur;
  int unsigned  m_age;
  logic [31:0]  m_first;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = '0;
      m_age = 0;
      m_first = '0;
    end else if (bus.stall[3] && !bus.stall[4]) begin
      m_cur = '0;
      m_age = 0;
    end else if (!bus.stall[3]) begin
      m_cur = bus.ex_to_mem_bus;
      m_age = 0;
    end else begin
      if (m_age == 0) m_first = bus.data_sram_rdata;
      if (m_age < 1000) m_age = m_age + 1;
    end
  end

  function automatic void model_out(input logic [145:0] c, input logic [31:0] w,
                                    output logic [136:0] wbx, output logic [103:0] idx);
    logic [31:0] exr, b, h, ld, wd;
    logic [2:0]  op;
    int          off;
    exr = c[31:0];
    op  = c[145:143];
    off = int'(exr[1:0]);
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      3'd1:    ld = (b ^ 32'h80) - 32'h80;
      3'd2:    ld = b;
      3'd3:    ld = (h ^ 32'h8000) - 32'h8000;
      3'd4:    ld = h;
      3'd5:    ld = w;
      default: ld = 32'd0;
    endcase
    wd  = c[38] ? ld : exr;
    wbx = {c[142], c[141], c[140], c[139:76], c[75:44], c[37], c[36:32], wd};
    idx = {c[142], c[141], c[139:76], c[37], c[36:32], wd};
  endfunction

  task automatic check(input string name, input logic [136:0] got, input logic [136:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Single compare process: every cycle, DUT outputs vs model.
  always @(negedge clk) begin
    logic [136:0] e_wb;
    logic [103:0] e_id;
    if (running) begin
      model_out(m_cur, (m_age == 0) ? bus.data_sram_rdata : m_first, e_wb, e_id);
      check("wb_bus", bus.mem_to_wb_bus, e_wb);
      check("id_bus", {33'd0, bus.mem_to_id_bus}, {33'd0, e_id});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [145:0] make_bus(
      input logic [2:0] op, input logic lo, input logic hi, input logic dmf,
      input logic [63:0] dmr, input logic [31:0] pc, input logic en, input logic [3:0] wen,
      input logic sel, input logic we, input logic [4:0] waddr, input logic [31:0] exr);
    return {op, lo, hi, dmf, dmr, pc, en, wen, sel, we, waddr, exr};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic lit_wdata(input string name, input logic [31:0] exp);
    #1;
    check(name, {105'd0, bus.mem_to_wb_bus[31:0]}, {105'd0, exp});
  endtask

  function automatic logic [145:0] rand_bus();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r[145:143] = 3'($urandom_range(0, 7));
    r[38]      = ($urandom_range(0, 3) != 0);
    return r[145:0];
  endfunction

  initial begin
    int sel;
    n_checks = 0;
    n_pass   = 0;
    running  = 1'b1;
    rst      = 1'b1;
    bus.stall = '0;
    bus.ex_to_mem_bus = '0;
    bus.data_sram_rdata = 32'hDEAD_BEEF;
    step();
    step();
    #1;
    check("reset_wb", bus.mem_to_wb_bus, '0);
    check("reset_id", {33'd0, bus.mem_to_id_bus}, '0);
    rst = 1'b0;

    // 1: LB / LBU offset 3
    bus.ex_to_mem_bus = make_bus(3'd1, 0, 0, 0, 64'd0, 32'h100, 1, 4'd0, 1, 1, 5'd2, 32'h0000_1003);
    step();
    bus.data_sram_rdata = 32'h80FF_1234;
    bus.ex_to_mem_bus = make_bus(3'd2, 0, 0, 0, 64'd0, 32'h104, 1, 4'd0, 1, 1, 5'd2, 32'h0000_1003);
    lit_wdata("lb_off3", 32'hFFFF_FF80);
    step();
    lit_wdata("lbu_off3", 32'h0000_0080);

    // 2: LH / LHU / LW
    bus.ex_to_mem_bus = make_bus(3'd3, 0, 0, 0, 64'd0, 32'h108, 1, 4'd0, 1, 1, 5'd3, 32'h0000_2002);
    step();
    bus.data_sram_rdata = 32'h8001_7FFF;
    bus.ex_to_mem_bus = make_bus(3'd4, 0, 0, 0, 64'd0, 32'h10C, 1, 4'd0, 1, 1, 5'd3, 32'h0000_2000);
    lit_wdata("lh_hi", 32'hFFFF_8001);
    step();
    bus.ex_to_mem_bus = make_bus(3'd5, 0, 0, 0, 64'd0, 32'h110, 1, 4'd0, 1, 1, 5'd3, 32'h0000_2003);
    lit_wdata("lhu_lo", 32'h0000_7FFF);
    step();
    lit_wdata("lw_off3", 32'h8001_7FFF);

    // 3: LW held three cycles, SRAM word changes underneath
    bus.ex_to_mem_bus = make_bus(3'd5, 0, 0, 0, 64'd0, 32'h114, 1, 4'd0, 1, 1, 5'd4, 32'h0000_3000);
    step();
    bus.data_sram_rdata = 32'hAAAA_AAAA;
    bus.stall = 6'b011000;
    bus.ex_to_mem_bus = rand_bus();
    lit_wdata("hold_c0", 32'hAAAA_AAAA);
    step();
    bus.data_sram_rdata = 32'h5555_5555;
    lit_wdata("hold_c1", 32'hAAAA_AAAA);
    step();
    lit_wdata("hold_c2", 32'hAAAA_AAAA);
    step();
    bus.stall = '0;
    lit_wdata("hold_release", 32'hAAAA_AAAA);

    // 4: bubble then reload
    bus.ex_to_mem_bus = make_bus(3'd0, 0, 0, 0, 64'd0, 32'h118, 0, 4'd0, 0, 1, 5'd9, 32'hCAFE_0001);
    step();
    bus.stall = 6'b001000;
    step();
    #1;
    check("bubble_wb", bus.mem_to_wb_bus, '0);
    check("bubble_id", {33'd0, bus.mem_to_id_bus}, '0);
    bus.stall = '0;
    step();
    lit_wdata("after_bubble", 32'hCAFE_0001);

    // 5: ALU op with HI write on both buses
    bus.ex_to_mem_bus = make_bus(3'd0, 0, 1, 0, 64'h1_0000_0002, 32'h0000_0200, 0, 4'd0, 0, 1,
                                 5'd8, 32'h1234_5678);
    step();
    #1;
    check("alu_wb", bus.mem_to_wb_bus,
          {1'b0, 1'b1, 1'b0, 64'h1_0000_0002, 32'h0000_0200, 1'b1, 5'd8, 32'h1234_5678});
    check("alu_id", {33'd0, bus.mem_to_id_bus},
          {33'd0, 1'b0, 1'b1, 64'h1_0000_0002, 1'b1, 5'd8, 32'h1234_5678});

    // 6: reset during a hold, then a fresh LW sees live data
    bus.ex_to_mem_bus = make_bus(3'd5, 0, 0, 0, 64'd0, 32'h120, 1, 4'd0, 1, 1, 5'd5, 32'h0000_4000);
    step();
    bus.data_sram_rdata = 32'hAAAA_AAAA;
    bus.stall = 6'b011000;
    step();
    bus.data_sram_rdata = 32'h5555_5555;
    rst = 1'b1;
    #1;
    check("rst_mid_hold", bus.mem_to_wb_bus, '0);
    rst = 1'b0;
    bus.stall = '0;
    step();
    lit_wdata("post_rst_lw", 32'h5555_5555);

    // randomised phase
    for (int i = 0; i < 400; i++) begin
      step();
      sel = $urandom_range(0, 3);
      bus.stall = 6'($urandom);
      bus.stall[3] = (sel >= 2);
      bus.stall[4] = (sel == 3);
      bus.ex_to_mem_bus = rand_bus();
      bus.data_sram_rdata = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end

    step();
    running = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
